// File: rtl/axis_video_pkg.sv
// Shared types and constants for the AXI4-Stream video monitor.
package axis_video_pkg;

    typedef enum logic [1:0] {
        READY_ALWAYS      = 2'd0,
        READY_RANDOM      = 2'd1,
        READY_AFTER_VALID = 2'd2,
        READY_DUTY        = 2'd3
    } ready_mode_e;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } fsm_state_e;

    localparam int LFSR_W     = 33;
    localparam int LFSR_TAP_A = 32;
    localparam int LFSR_TAP_B = 19;
    localparam int SUM_W      = 32;

    // One step of the 33-bit XNOR-feedback shift register.
    function automatic logic [LFSR_W-1:0] lfsrStep(input logic [LFSR_W-1:0] state);
        return {state[LFSR_W-2:0], state[LFSR_TAP_A] ^ ~state[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/axis_video_monitor_ready_gen.sv
// Registered tready generator with selectable backpressure patterns.
// The LFSR free-runs in every mode; the duty counter only runs in duty
// mode so the pattern always starts with its high phase when entered.
module axis_ready_gen
    import axis_video_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RND_SEED = 33'h04A4C6E4A,
    parameter int                DUTY_ON  = 3,
    parameter int                DUTY_OFF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ready_mode_i,
    input  logic       s_tvalid_i,
    input  logic       handshake_i,
    output logic       s_tready_o
);

    localparam int DUTY_PERIOD = DUTY_ON + DUTY_OFF;
    localparam int DUTY_W      = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
    localparam logic [DUTY_W-1:0] DUTY_LAST   = DUTY_W'(DUTY_PERIOD - 1);
    localparam logic [DUTY_W:0]   DUTY_ON_CMP = (DUTY_W + 1)'(DUTY_ON);

    ready_mode_e       mode;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DUTY_W-1:0] dutyCnt_q, dutyCnt_d;
    logic              ready_q, ready_d;

    assign mode       = ready_mode_e'(ready_mode_i);
    assign s_tready_o = ready_q;

    // Next ready value per mode; random mode tracks the MSB of the stepped LFSR.
    always_comb begin
        lfsr_d    = lfsrStep(lfsr_q);
        dutyCnt_d = '0;
        ready_d   = 1'b0;
        case (mode)
            READY_ALWAYS:      ready_d = 1'b1;
            READY_RANDOM:      ready_d = lfsr_d[LFSR_TAP_A];
            READY_AFTER_VALID: ready_d = s_tvalid_i & ~handshake_i;
            READY_DUTY: begin
                ready_d   = ({1'b0, dutyCnt_q} < DUTY_ON_CMP);
                dutyCnt_d = (dutyCnt_q == DUTY_LAST) ? '0 : dutyCnt_q + 1'b1;
            end
            default:           ready_d = 1'b0;
        endcase
    end

    // State registers for the LFSR, duty phase and the registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q    <= RND_SEED;
            dutyCnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            dutyCnt_q <= dutyCnt_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: rtl/axis_video_monitor.sv
// AXI4-Stream video sink/monitor: framing checks, checksum, timeout watchdog
// and saturating error counters. Assumes Y_SIZE >= 2 so line_idx has width.
module axis_video_monitor
    import axis_video_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                X_SIZE   = 480,
    parameter int                Y_SIZE   = 480,
    parameter int                TIMEOUT  = 1000,
    parameter int                CNT_W    = 16,
    parameter logic [LFSR_W-1:0] RND_SEED = 33'h04A4C6E4A,
    parameter int                DUTY_ON  = 3,
    parameter int                DUTY_OFF = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tuser,
    input  logic                      s_tlast,
    output logic                      s_tready,
    input  logic [1:0]                ready_mode,
    input  logic                      clr_errors,
    output logic [CNT_W-1:0]          frame_count,
    output logic [$clog2(Y_SIZE)-1:0] line_idx,
    output logic                      frame_done,
    output logic [SUM_W-1:0]          frame_sum,
    output logic [CNT_W-1:0]          err_sof_missing,
    output logic [CNT_W-1:0]          err_sof_unexpected,
    output logic [CNT_W-1:0]          err_eol_missing,
    output logic [CNT_W-1:0]          err_eol_unexpected,
    output logic [CNT_W-1:0]          err_timeout,
    output logic                      any_error
);

    localparam int X_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int Y_W = $clog2(Y_SIZE);
    localparam int T_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);

    fsm_state_e       state_q, state_d;
    logic [X_W-1:0]   xPos_q, xPos_d, curX;
    logic [Y_W-1:0]   yPos_q, yPos_d, curY;
    logic [SUM_W-1:0] sum_q, sum_d, curSum;
    logic             sofGuard_q, sofGuard_d;
    logic             frameDone_q, frameDone_d;
    logic [SUM_W-1:0] frameSum_q, frameSum_d;
    logic [T_W-1:0]   timeoutCnt_q, timeoutCnt_d;
    logic [CNT_W-1:0] frameCount_q, frameCount_d;
    logic [CNT_W-1:0] errSofMissing_q, errSofMissing_d;
    logic [CNT_W-1:0] errSofUnexp_q, errSofUnexp_d;
    logic [CNT_W-1:0] errEolMissing_q, errEolMissing_d;
    logic [CNT_W-1:0] errEolUnexp_q, errEolUnexp_d;
    logic [CNT_W-1:0] errTimeout_q, errTimeout_d;
    logic             anyError_q, anyError_d;

    logic             beat;
    logic [SUM_W-1:0] beatWord;
    logic             processBeat, lineEnd;
    logic             evtFrameStart, evtSofMissing, evtSofUnexp;
    logic             evtEolMissing, evtEolUnexp, evtTimeout;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value, input logic enable);
        if (enable && (value != {CNT_W{1'b1}})) return value + 1'b1;
        return value;
    endfunction

    assign beat     = s_tvalid & s_tready;
    assign beatWord = SUM_W'(s_tdata);

    axis_ready_gen #(
        .RND_SEED (RND_SEED),
        .DUTY_ON  (DUTY_ON),
        .DUTY_OFF (DUTY_OFF)
    ) u_ready_gen (
        .clk          (clk),
        .rst          (rst),
        .ready_mode_i (ready_mode),
        .s_tvalid_i   (s_tvalid),
        .handshake_i  (beat),
        .s_tready_o   (s_tready)
    );

    // Framing FSM: an SOF (expected or not) restarts at (0,0) before the EOL check runs.
    always_comb begin
        state_d       = state_q;
        xPos_d        = xPos_q;
        yPos_d        = yPos_q;
        sum_d         = sum_q;
        sofGuard_d    = sofGuard_q;
        frameDone_d   = 1'b0;
        frameSum_d    = frameSum_q;
        curX          = xPos_q;
        curY          = yPos_q;
        curSum        = sum_q;
        processBeat   = 1'b0;
        lineEnd       = 1'b0;
        evtFrameStart = 1'b0;
        evtSofMissing = 1'b0;
        evtSofUnexp   = 1'b0;
        evtEolMissing = 1'b0;
        evtEolUnexp   = 1'b0;

        if (beat) begin
            case (state_q)
                WAIT_SOF: begin
                    if (s_tuser) begin
                        evtFrameStart = 1'b1;
                        processBeat   = 1'b1;
                        curX          = '0;
                        curY          = '0;
                        curSum        = '0;
                        sofGuard_d    = 1'b0;
                    end else if (!sofGuard_q) begin
                        evtSofMissing = 1'b1;
                        sofGuard_d    = 1'b1;
                    end
                end
                IN_FRAME: begin
                    processBeat = 1'b1;
                    if (s_tuser && ((xPos_q != '0) || (yPos_q != '0))) begin
                        evtSofUnexp   = 1'b1;
                        evtFrameStart = 1'b1;
                        curX          = '0;
                        curY          = '0;
                        curSum        = '0;
                    end
                end
                default: ;
            endcase
        end

        if (processBeat) begin
            sum_d   = curSum + beatWord;
            state_d = IN_FRAME;
            xPos_d  = curX;
            yPos_d  = curY;
            if (curX == X_LAST) begin
                lineEnd       = 1'b1;
                evtEolMissing = ~s_tlast;
            end else if (s_tlast) begin
                lineEnd     = 1'b1;
                evtEolUnexp = 1'b1;
            end else begin
                xPos_d = curX + 1'b1;
            end
            if (lineEnd) begin
                xPos_d = '0;
                if (curY == Y_LAST) begin
                    yPos_d      = '0;
                    state_d     = WAIT_SOF;
                    frameDone_d = 1'b1;
                    frameSum_d  = sum_d;
                    sofGuard_d  = 1'b0;
                end else begin
                    yPos_d = curY + 1'b1;
                end
            end
        end
    end

    // Valid watchdog: counts idle cycles and fires once every TIMEOUT of them.
    always_comb begin
        evtTimeout   = 1'b0;
        timeoutCnt_d = timeoutCnt_q;
        if (s_tvalid) begin
            timeoutCnt_d = '0;
        end else if (timeoutCnt_q == T_LAST) begin
            evtTimeout   = 1'b1;
            timeoutCnt_d = '0;
        end else begin
            timeoutCnt_d = timeoutCnt_q + 1'b1;
        end
    end

    // Saturating counters; a clear beats any event raised in the same cycle.
    always_comb begin
        frameCount_d    = satInc(frameCount_q, evtFrameStart);
        errSofMissing_d = '0;
        errSofUnexp_d   = '0;
        errEolMissing_d = '0;
        errEolUnexp_d   = '0;
        errTimeout_d    = '0;
        anyError_d      = 1'b0;
        if (!clr_errors) begin
            errSofMissing_d = satInc(errSofMissing_q, evtSofMissing);
            errSofUnexp_d   = satInc(errSofUnexp_q, evtSofUnexp);
            errEolMissing_d = satInc(errEolMissing_q, evtEolMissing);
            errEolUnexp_d   = satInc(errEolUnexp_q, evtEolUnexp);
            errTimeout_d    = satInc(errTimeout_q, evtTimeout);
            anyError_d      = anyError_q | evtSofMissing | evtSofUnexp |
                              evtEolMissing | evtEolUnexp | evtTimeout;
        end
    end

    // All monitor state, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= WAIT_SOF;
            xPos_q          <= '0;
            yPos_q          <= '0;
            sum_q           <= '0;
            sofGuard_q      <= 1'b0;
            frameDone_q     <= 1'b0;
            frameSum_q      <= '0;
            timeoutCnt_q    <= '0;
            frameCount_q    <= '0;
            errSofMissing_q <= '0;
            errSofUnexp_q   <= '0;
            errEolMissing_q <= '0;
            errEolUnexp_q   <= '0;
            errTimeout_q    <= '0;
            anyError_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            xPos_q          <= xPos_d;
            yPos_q          <= yPos_d;
            sum_q           <= sum_d;
            sofGuard_q      <= sofGuard_d;
            frameDone_q     <= frameDone_d;
            frameSum_q      <= frameSum_d;
            timeoutCnt_q    <= timeoutCnt_d;
            frameCount_q    <= frameCount_d;
            errSofMissing_q <= errSofMissing_d;
            errSofUnexp_q   <= errSofUnexp_d;
            errEolMissing_q <= errEolMissing_d;
            errEolUnexp_q   <= errEolUnexp_d;
            errTimeout_q    <= errTimeout_d;
            anyError_q      <= anyError_d;
        end
    end

    assign frame_count        = frameCount_q;
    assign line_idx           = yPos_q;
    assign frame_done         = frameDone_q;
    assign frame_sum          = frameSum_q;
    assign err_sof_missing    = errSofMissing_q;
    assign err_sof_unexpected = errSofUnexp_q;
    assign err_eol_missing    = errEolMissing_q;
    assign err_eol_unexpected = errEolUnexp_q;
    assign err_timeout        = errTimeout_q;
    assign any_error          = anyError_q;

endmodule
